alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter CNT_W, default 4: width of the saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer can accept a command this cycle.
REQ-006 cmd_op  input  3  opcode: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 CLEAR.
REQ-007 cmd_a, cmd_b  input  8 each  operands.
REQ-008 cmd_chain  input  1  use last captured result instead of cmd_a as first operand.
REQ-009 alu_in_sel  output  3  one-hot to downstream ALU input mux: bit2 persist, bit1 load, bit0 reset.
REQ-010 alu_num1, alu_num2  output  8 each  operands to ALU.
REQ-011 alu_out_sel  output  7  one-hot ALU result select: bit6 AND, bit5 OR, bit4 NOT, bit3 XOR, bit2 ADD, bit1 SUB, bit0 MULT.
REQ-012 alu_result  input  8  ALU output, combinational from ALU operand registers.
REQ-013 alu_overflow  input  1  ALU multiply overflow flag.
REQ-014 rsp_valid  output  1; rsp_ready  input  1; rsp_data  output  8; rsp_error  output  1.
REQ-015 err_count  output  CNT_W  saturating count of responses with rsp_error=1.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, SAMPLE, RESP; cmd_ready SHALL be high only in IDLE.
REQ-018 IDLE->ISSUE on cmd_valid&&cmd_ready; op, operands, chain latched at that edge (E0).
REQ-019 ISSUE and SAMPLE SHALL drive alu_in_sel=load (3'b010), alu_num1 = chain ? last_result : latched a, alu_num2 = latched b, alu_out_sel = one-hot of op; values held identical across both states.
REQ-020 CLEAR SHALL drive alu_in_sel=reset (3'b001), alu_out_sel=bit6, and force captured data to 8'h00.
REQ-021 ISSUE->SAMPLE unconditionally at E1; SAMPLE->RESP unconditionally at E2, capturing alu_result into rsp_data and (alu_overflow && op==MULT) into rsp_error.
REQ-022 rsp_valid SHALL be high exactly in RESP, first asserted 2 cycles after acceptance edge; rsp_data/rsp_error stable while rsp_valid && !rsp_ready.
REQ-023 RESP->IDLE on rsp_ready; no same-cycle bypass, so next cmd_ready rises the cycle after the handshake; minimum command spacing 4 cycles.
REQ-024 last_result SHALL update to rsp_data at E2 (0 for CLEAR); err_count increments at E2 when rsp_error=1 and saturates at all-ones.
REQ-025 IDLE SHALL drive alu_in_sel=load, alu_num1=last_result, alu_num2=8'h00, alu_out_sel=bit5 (OR), keeping the ALU accumulator equal to last_result.
REQ-026 cmd_valid while not IDLE SHALL be ignored (no latch, no state change).
REQ-027 SUB/ADD results wrap modulo 256; no error raised for them.

Reset
REQ-028 rst SHALL asynchronously force IDLE, rsp_valid=0, rsp_data=0, rsp_error=0, last_result=0, err_count=0, busy=0, cmd_ready=1, ALU outputs to IDLE values.
REQ-029 rst mid-operation (ISSUE/SAMPLE/RESP) SHALL discard the command with no response issued.

Structure
REQ-030 Shared package SHALL hold the state encoding (2-bit), opcode constants, one-hot in_sel and out_sel constants.
REQ-031 One sub-module alu_op_decode (combinational opcode -> out_sel/in_sel) is natural; all else in one module.

Verification
REQ-032 ADD a=8'h0F b=8'h01 -> rsp_valid 2 cycles after accept, rsp_data=8'h10, rsp_error=0.
REQ-033 MULT a=8'h20 b=8'h10 with ALU overflow=1 -> rsp_error=1, err_count=1; repeat 20 times -> err_count saturates at 4'hF.
REQ-034 CLEAR, then ADD chain=1 b=8'h05 -> rsp_data=8'h05; second chained ADD b=8'hFF -> rsp_data=8'h04 (wrap).
REQ-035 rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable; cmd_valid during that time ignored; cmd_ready returns the cycle after handshake.
REQ-036 rst asserted in SAMPLE -> immediately IDLE, no rsp_valid, last_result=0.
REQ-037 Back-to-back cmd_valid with rsp_ready=1 -> accepts spaced exactly 4 cycles.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared encodings for the ALU operation sequencer: FSM states, opcodes and
// the one-hot select codes understood by the downstream ALU.
package alu_op_sequencer_pkg;

    typedef logic [1:0] state_t;
    typedef logic [2:0] opcode_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ISSUE  = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    localparam opcode_t OP_AND   = 3'd0;
    localparam opcode_t OP_OR    = 3'd1;
    localparam opcode_t OP_NOT   = 3'd2;
    localparam opcode_t OP_XOR   = 3'd3;
    localparam opcode_t OP_ADD   = 3'd4;
    localparam opcode_t OP_SUB   = 3'd5;
    localparam opcode_t OP_MULT  = 3'd6;
    localparam opcode_t OP_CLEAR = 3'd7;

    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_RESET   = 3'b001;

    localparam logic [6:0] OUT_SEL_AND  = 7'b1000000;
    localparam logic [6:0] OUT_SEL_OR   = 7'b0100000;
    localparam logic [6:0] OUT_SEL_NOT  = 7'b0010000;
    localparam logic [6:0] OUT_SEL_XOR  = 7'b0001000;
    localparam logic [6:0] OUT_SEL_ADD  = 7'b0000100;
    localparam logic [6:0] OUT_SEL_SUB  = 7'b0000010;
    localparam logic [6:0] OUT_SEL_MULT = 7'b0000001;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU-side signals of the sequencer. The slave modport
// is the sequencer; the master modport is the surrounding environment.
interface alu_op_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_chain;

    logic [2:0] alu_in_sel;
    logic [7:0] alu_num1;
    logic [7:0] alu_num2;
    logic [6:0] alu_out_sel;
    logic [7:0] alu_result;
    logic       alu_overflow;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_error;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
        output alu_result, alu_overflow, rsp_ready,
        input  cmd_ready, alu_in_sel, alu_num1, alu_num2, alu_out_sel,
        input  rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
        input  alu_result, alu_overflow, rsp_ready,
        output cmd_ready, alu_in_sel, alu_num1, alu_num2, alu_out_sel,
        output rsp_valid, rsp_data, rsp_error
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decode into the ALU's one-hot input and result selects.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
(
    input  logic [2:0] op,
    output logic [6:0] out_sel,
    output logic [2:0] in_sel
);

    always_comb begin
        in_sel  = IN_SEL_LOAD;
        out_sel = OUT_SEL_AND;
        case (op)
            OP_AND:   out_sel = OUT_SEL_AND;
            OP_OR:    out_sel = OUT_SEL_OR;
            OP_NOT:   out_sel = OUT_SEL_NOT;
            OP_XOR:   out_sel = OUT_SEL_XOR;
            OP_ADD:   out_sel = OUT_SEL_ADD;
            OP_SUB:   out_sel = OUT_SEL_SUB;
            OP_MULT:  out_sel = OUT_SEL_MULT;
            // CLEAR zeroes the ALU operand registers; AND of zeros reads back 0
            OP_CLEAR: begin
                in_sel  = IN_SEL_RESET;
                out_sel = OUT_SEL_AND;
            end
            default:  out_sel = OUT_SEL_AND;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time through an external registered ALU:
// issue operands, sample the result a cycle later, then hold the response.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  bus,
    output logic [CNT_W-1:0]   err_count,
    output logic               busy
);

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic             chain_q, chain_d;
    logic [7:0]       last_q, last_d;
    logic [7:0]       data_q, data_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0]       dec_out_sel;
    logic [2:0]       dec_in_sel;

    alu_op_decode u_decode (
        .op      (op_q),
        .out_sel (dec_out_sel),
        .in_sel  (dec_in_sel)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        chain_d = chain_q;
        last_d  = last_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = ST_ISSUE;
                    op_d    = bus.cmd_op;
                    a_d     = bus.cmd_a;
                    b_d     = bus.cmd_b;
                    chain_d = bus.cmd_chain;
                end
            end
            ST_ISSUE: state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                state_d = ST_RESP;
                data_d  = (op_q == OP_CLEAR) ? 8'h00 : bus.alu_result;
                err_d   = bus.alu_overflow && (op_q == OP_MULT);
                last_d  = data_d;
                if (err_d && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            chain_q <= 1'b0;
            last_q  <= 8'h00;
            data_q  <= 8'h00;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            chain_q <= chain_d;
            last_q  <= last_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Idle keeps the ALU accumulator tracking last_q (OR with zero); the
    // response state freezes the ALU since its result is already captured.
    always_comb begin
        bus.alu_in_sel  = IN_SEL_LOAD;
        bus.alu_num1    = last_q;
        bus.alu_num2    = 8'h00;
        bus.alu_out_sel = OUT_SEL_OR;
        case (state_q)
            ST_ISSUE, ST_SAMPLE: begin
                bus.alu_in_sel  = dec_in_sel;
                bus.alu_num1    = chain_q ? last_q : a_q;
                bus.alu_num2    = b_q;
                bus.alu_out_sel = dec_out_sel;
            end
            ST_RESP: begin
                bus.alu_in_sel  = IN_SEL_PERSIST;
                bus.alu_num1    = chain_q ? last_q : a_q;
                bus.alu_num2    = b_q;
                bus.alu_out_sel = dec_out_sel;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_error = err_q;
    assign err_count     = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural registered ALU;
// expected responses are queued at issue and checked by a separate monitor.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] err_count;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] exp_q[$];

    alu_op_sequencer_if bus();

    alu_op_sequencer #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: operand registers plus a combinational one-hot result mux
    logic [7:0]  alu_ra, alu_rb;
    logic [15:0] alu_prod;

    always @(posedge clk) begin
        if (bus.alu_in_sel == 3'b010) begin
            alu_ra <= bus.alu_num1;
            alu_rb <= bus.alu_num2;
        end else if (bus.alu_in_sel == 3'b001) begin
            alu_ra <= 8'h00;
            alu_rb <= 8'h00;
        end
    end

    always_comb begin
        alu_prod         = {8'h00, alu_ra} * {8'h00, alu_rb};
        bus.alu_overflow = (bus.alu_out_sel == 7'b0000001) && (alu_prod[15:8] != 8'h00);
        case (bus.alu_out_sel)
            7'b1000000: bus.alu_result = alu_ra & alu_rb;
            7'b0100000: bus.alu_result = alu_ra | alu_rb;
            7'b0010000: bus.alu_result = ~alu_ra;
            7'b0001000: bus.alu_result = alu_ra ^ alu_rb;
            7'b0000100: bus.alu_result = alu_ra + alu_rb;
            7'b0000010: bus.alu_result = alu_ra - alu_rb;
            7'b0000001: bus.alu_result = alu_prod[7:0];
            default:    bus.alu_result = 8'h00;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Monitor: every completed response handshake pops one expectation
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    timeoutFail("rsp_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rsp_data", 32'(bus.rsp_data), 32'(e[7:0]));
                    checkOutput("rsp_error", 32'(bus.rsp_error), 32'(e[8]));
                end
            end
        end
    end

    task automatic waitCmdReady(input string name);
        int n = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeoutFail(name);
    endtask

    // Offers one command, queues its expected response, returns just after acceptance
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic chain, input logic [7:0] exp_data, input logic exp_err);
        waitCmdReady("cmd_ready_wait");
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_chain = chain;
        exp_q.push_back({exp_err, exp_data});
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic awaitResponse();
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 20);
        checkOutput("rsp_latency", 32'(lat - 1), 32'd2);
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic chain, input logic [7:0] exp_data, input logic exp_err);
        applyStimulus(op, a, b, chain, exp_data, exp_err);
        awaitResponse();
    endtask

    initial begin
        time t_acc[3];
        logic [2:0] bb_op[3];
        logic [7:0] bb_a[3], bb_b[3], bb_exp[3];
        int n;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_AND;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.cmd_chain = 1'b0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_sel", 32'(bus.alu_in_sel), 32'h2);
        checkOutput("rst_num1", 32'(bus.alu_num1), 32'h00);
        checkOutput("rst_num2", 32'(bus.alu_num2), 32'h00);
        checkOutput("rst_out_sel", 32'(bus.alu_out_sel), 32'h20);
        rst = 1'b0;

        runOp(OP_ADD, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        checkOutput("add_err_count", 32'(err_count), 32'd0);
        checkOutput("idle_num1_last", 32'(bus.alu_num1), 32'h10);
        checkOutput("idle_out_sel", 32'(bus.alu_out_sel), 32'h20);

        for (int i = 0; i < 20; i++) begin
            runOp(OP_MULT, 8'h20, 8'h10, 1'b0, 8'h00, 1'b1);
            checkOutput("mult_err_count", 32'(err_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end

        runOp(OP_SUB, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0);
        runOp(OP_NOT, 8'h5A, 8'h00, 1'b0, 8'hA5, 1'b0);
        runOp(OP_CLEAR, 8'hAA, 8'h55, 1'b0, 8'h00, 1'b0);
        runOp(OP_ADD, 8'hEE, 8'h05, 1'b1, 8'h05, 1'b0);
        runOp(OP_ADD, 8'hEE, 8'hFF, 1'b1, 8'h04, 1'b0);
        checkOutput("wrap_err_count", 32'(err_count), 32'd15);

        // Response stall: data must hold and new commands must be ignored
        bus.rsp_ready = 1'b0;
        applyStimulus(OP_XOR, 8'hA5, 8'h3C, 1'b0, 8'h99, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.rsp_valid !== 1'b1 && n < 20);
        checkOutput("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_OR;
        bus.cmd_a     = 8'hFF;
        bus.cmd_b     = 8'hFF;
        bus.cmd_chain = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("stall_data", 32'(bus.rsp_data), 32'h99);
            checkOutput("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("pre_hs_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        checkOutput("post_hs_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("post_hs_busy", 32'(busy), 32'd0);

        // Back-to-back: cmd_valid held high, accepts must be 4 cycles apart
        bb_op[0] = OP_OR;  bb_a[0] = 8'h0F; bb_b[0] = 8'hF0; bb_exp[0] = 8'hFF;
        bb_op[1] = OP_AND; bb_a[1] = 8'hF0; bb_b[1] = 8'h3C; bb_exp[1] = 8'h30;
        bb_op[2] = OP_SUB; bb_a[2] = 8'h03; bb_b[2] = 8'h05; bb_exp[2] = 8'hFE;
        for (int k = 0; k < 3; k++) begin
            waitCmdReady("b2b_wait");
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = bb_op[k];
            bus.cmd_a     = bb_a[k];
            bus.cmd_b     = bb_b[k];
            bus.cmd_chain = 1'b0;
            exp_q.push_back({1'b0, bb_exp[k]});
            @(posedge clk);
            t_acc[k] = $time;
        end
        #1 bus.cmd_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            checkOutput("b2b_spacing", 32'((t_acc[k] - t_acc[k-1]) / 10), 32'd4);
        end
        repeat (5) @(negedge clk);
        checkOutput("b2b_last_result", 32'(bus.alu_num1), 32'hFE);

        // Reset while in SAMPLE: command dropped, no response, history cleared
        waitCmdReady("rst_mid_wait");
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ADD;
        bus.cmd_a     = 8'h01;
        bus.cmd_b     = 8'h01;
        bus.cmd_chain = 1'b0;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mid_rst_last_result", 32'(bus.alu_num1), 32'h00);
        checkOutput("mid_rst_err_count", 32'(err_count), 32'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        runOp(OP_ADD, 8'h99, 8'h07, 1'b1, 8'h07, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
